// File: rtl/ld_inc_seq_pkg.sv
// Shared state encoding and default widths for the load/increment sequencer.
package ld_inc_seq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_GAP_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INC,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/ld_inc_seq_dcnt.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count never wraps below zero.
module ld_inc_seq_dcnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/ld_inc_seq.sv
// Command sequencer: one load strobe, then a programmed number of increment
// strobes separated by a programmed idle gap, ending with a done pulse.
module ld_inc_seq
   import ld_inc_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int GAP_W = DEF_GAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_base,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [GAP_W-1:0] cmd_gap,
   input  logic             abort,
   output logic             ld,
   output logic             inc,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   state_t           state;
   logic [GAP_W-1:0] gap_cfg;
   logic             accept;
   logic             rem_zero;
   logic             gap_zero;
   logic             go_inc;
   logic             go_gap;
   logic             go_done;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Remaining count drops as each increment is issued, so in INC a zero
   // flag means the strobe just issued was the last one.
   always_comb begin
      go_inc  = 1'b0;
      go_gap  = 1'b0;
      go_done = 1'b0;
      case (state)
         LOAD: begin
            if (abort || rem_zero) go_done = 1'b1;
            else                   go_inc  = 1'b1;
         end
         INC: begin
            if (abort || rem_zero)    go_done = 1'b1;
            else if (gap_cfg == '0)   go_inc  = 1'b1;
            else                      go_gap  = 1'b1;
         end
         GAP: begin
            if (abort)         go_done = 1'b1;
            else if (gap_zero) go_inc  = 1'b1;
         end
         default: ;
      endcase
   end

   ld_inc_seq_dcnt #(.W(CNT_W)) u_rem (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (cmd_count),
      .dec      (go_inc),
      .zero     (rem_zero)
   );

   // Gap counter holds gap-1 on entry so GAP lasts exactly gap cycles.
   ld_inc_seq_dcnt #(.W(GAP_W)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (go_gap),
      .load_val (gap_cfg - GAP_W'(1)),
      .dec      ((state == GAP) && !go_inc && !go_done),
      .zero     (gap_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gap_cfg <= '0;
         ld      <= 1'b0;
         inc     <= 1'b0;
         data    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         ld      <= 1'b0;
         inc     <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= LOAD;
                  ld      <= 1'b1;
                  data    <= cmd_base;
                  gap_cfg <= cmd_gap;
                  busy    <= 1'b1;
               end
            end
            LOAD, INC, GAP: begin
               if (go_done) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  aborted <= abort;
               end else if (go_inc) begin
                  state <= INC;
                  inc   <= 1'b1;
               end else if (go_gap) begin
                  state <= GAP;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ld_inc_seq.sv
// Directed bench for ld_inc_seq with a behavioural downstream load/increment
// register; cycle numbers are counted from the accepting edge.
module tb_ld_inc_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_base;
   logic [7:0] cmd_count;
   logic [3:0] cmd_gap;
   logic       abort;
   logic       ld;
   logic       inc;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic       aborted;

   logic [7:0] ds;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         overlap  = 0;

   always #5 clk = ~clk;

   ld_inc_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_count (cmd_count),
      .cmd_gap   (cmd_gap),
      .abort     (abort),
      .ld        (ld),
      .inc       (inc),
      .data      (data),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ds <= 8'h00;
      else if (ld)  ds <= data;
      else if (inc) ds <= ds + 8'h01;
   end

   always @(negedge clk) begin
      if (ld && inc) overlap <= overlap + 1;
   end

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Issues one command and traces strobes until done or the cycle budget ends.
   task automatic apply_stimulus(input logic [7:0] b, input logic [7:0] n, input logic [3:0] g,
                                 input int abort_at, input int max_cyc,
                                 output logic [63:0] ldm, output logic [63:0] incm,
                                 output int done_at, output logic ab, output logic [7:0] d_done);
      int w;
      ldm = '0; incm = '0; done_at = -1; ab = 1'b0; d_done = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_base = b; cmd_count = n; cmd_gap = g;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (c < 64) begin
            ldm[c]  = ld;
            incm[c] = inc;
         end
         abort = (c == abort_at);
         if (done) begin
            done_at = c;
            ab      = aborted;
            d_done  = data;
            abort   = 1'b0;
            break;
         end
      end
      abort = 1'b0;
   endtask

   logic [63:0] ldm, incm, donem, readym;
   int          done_at;
   logic        ab;
   logic [7:0]  d_done, d1, d5, ds7;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = 8'h00; cmd_count = 8'h00;
      cmd_gap = 4'h0; abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("rst_ld", 64'(ld), 64'd0);
      check_output("rst_inc", 64'(inc), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_aborted", 64'(aborted), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_data", 64'(data), 64'd0);
      check_output("rst_ready", 64'(cmd_ready), 64'd1);
      rst_n = 1'b1;

      apply_stimulus(8'h10, 8'd3, 4'd0, 0, 40, ldm, incm, done_at, ab, d_done);
      check_output("t1_ld", ldm, 64'h2);
      check_output("t1_inc", incm, 64'h1C);
      check_output("t1_done", 64'(done_at), 64'd5);
      check_output("t1_ab", 64'(ab), 64'd0);
      check_output("t1_reg", 64'(ds), 64'h13);
      check_output("t1_data", 64'(d_done), 64'h10);

      apply_stimulus(8'hFE, 8'd4, 4'd2, 0, 40, ldm, incm, done_at, ab, d_done);
      check_output("t2_ld", ldm, 64'h2);
      check_output("t2_inc", incm, 64'h924);
      check_output("t2_done", 64'(done_at), 64'd12);
      check_output("t2_reg", 64'(ds), 64'h02);

      apply_stimulus(8'hA5, 8'd0, 4'd3, 0, 40, ldm, incm, done_at, ab, d_done);
      check_output("t3_ld", ldm, 64'h2);
      check_output("t3_inc", incm, 64'h0);
      check_output("t3_done", 64'(done_at), 64'd2);
      check_output("t3_ab", 64'(ab), 64'd0);
      check_output("t3_reg", 64'(ds), 64'hA5);

      apply_stimulus(8'h00, 8'd10, 4'd1, 7, 60, ldm, incm, done_at, ab, d_done);
      check_output("t4_inc", incm, 64'h54);
      check_output("t4_done", 64'(done_at), 64'd8);
      check_output("t4_ab", 64'(ab), 64'd1);
      check_output("t4_reg", 64'(ds), 64'h03);

      apply_stimulus(8'h80, 8'd255, 4'd0, 0, 300, ldm, incm, done_at, ab, d_done);
      check_output("t5_done", 64'(done_at), 64'd257);
      check_output("t5_ab", 64'(ab), 64'd0);
      check_output("t5_reg", 64'(ds), 64'h7F);

      // reset pulse in the middle of an increment run
      @(negedge clk);
      cmd_valid = 1'b1; cmd_base = 8'h30; cmd_count = 8'd5; cmd_gap = 4'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_output("rs_pre_inc", 64'(inc), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_output("rs_ld", 64'(ld), 64'd0);
      check_output("rs_inc", 64'(inc), 64'd0);
      check_output("rs_done", 64'(done), 64'd0);
      check_output("rs_busy", 64'(busy), 64'd0);
      check_output("rs_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cmd_valid = 1'b1; cmd_base = 8'h55; cmd_count = 8'd0; cmd_gap = 4'd0;
      @(negedge clk);
      check_output("rs_new_ld", 64'(ld), 64'd1);
      check_output("rs_new_data", 64'(data), 64'h55);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_output("rs_new_done", 64'(done), 64'd1);

      // back-to-back commands with cmd_valid held
      @(negedge clk);
      cmd_valid = 1'b1; cmd_base = 8'h20; cmd_count = 8'd1; cmd_gap = 4'd0;
      ldm = '0; donem = '0; readym = '0; d1 = 8'h00; d5 = 8'h00; ds7 = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         ldm[c]    = ld;
         donem[c]  = done;
         readym[c] = cmd_ready;
         if (c == 1) d1 = data;
         if (c == 2) cmd_base = 8'h40;
         if (c == 5) begin
            d5 = data;
            cmd_valid = 1'b0;
         end
         if (c == 7) ds7 = ds;
      end
      check_output("b2b_ld", ldm, 64'h22);
      check_output("b2b_done", donem, 64'h88);
      check_output("b2b_ready", readym, 64'h110);
      check_output("b2b_data1", 64'(d1), 64'h20);
      check_output("b2b_data2", 64'(d5), 64'h40);
      check_output("b2b_reg", 64'(ds7), 64'h41);
      check_output("ld_inc_excl", 64'(overlap), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
